// File: rtl/fused_buf_pkg.sv
// Shared types and constants for the fused-layer ping-pong tile buffer.
package fused_buf_pkg;
   localparam int DATA_W = 128;
   typedef logic [DATA_W-1:0] fused_word_t;
   typedef logic bank_sel_t;
endpackage

// File: rtl/fused_bank_ram.sv
// Two-bank simple dual-port RAM. The registered read port doubles as the output data register.
module fused_bank_ram #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic              wr_bank,
   input  logic [ADDR_W-1:0] wr_ptr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic              rd_bank,
   input  logic [ADDR_W-1:0] rd_ptr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem_q [2*DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[{wr_bank, wr_ptr}] <= wr_data;
      end
   end

   // Only the read register is cleared so the output word reads zero after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= mem_q[{rd_bank, rd_ptr}];
      end
   end

   assign rd_data = rd_data_q;
endmodule

// File: rtl/fused_tile_buffer.sv
// Ping-pong tile buffer: fills one bank from the packer while the other streams
// out over valid/ready; flags dropped words when both banks hold complete tiles.
module fused_tile_buffer #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [1:0]        bank_full,
   output logic              overflow,
   output logic              tile_done
);
   import fused_buf_pkg::*;

   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   bank_sel_t         wr_bank_q, wr_bank_d;
   bank_sel_t         rd_bank_q, rd_bank_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [1:0]        bank_full_q, bank_full_d;
   logic              overflow_q, overflow_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              wr_en;
   logic              issue;

   always_comb begin
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      bank_full_d = bank_full_q;
      overflow_d  = overflow_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;

      wr_en = in_valid && !bank_full_q[wr_bank_q];
      issue = bank_full_q[rd_bank_q] && (!out_valid_q || out_ready);

      if (in_valid && !wr_en) begin
         overflow_d = 1'b1;
      end

      // Set and clear can never hit the same bank: one needs it empty, the other full.
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (wr_ptr_q == LAST_IDX) begin
            wr_ptr_d               = '0;
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
         end
      end

      if (issue) begin
         out_valid_d = 1'b1;
         out_last_d  = (rd_ptr_q == LAST_IDX);
         rd_ptr_d    = rd_ptr_q + 1'b1;
         if (rd_ptr_q == LAST_IDX) begin
            rd_ptr_d               = '0;
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         bank_full_q <= 2'b00;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         bank_full_q <= bank_full_d;
         overflow_q  <= overflow_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   fused_bank_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_bank (wr_bank_q),
      .wr_ptr  (wr_ptr_q),
      .wr_data (in_data),
      .rd_en   (issue),
      .rd_bank (rd_bank_q),
      .rd_ptr  (rd_ptr_q),
      .rd_data (out_data)
   );

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign bank_full = bank_full_q;
   assign overflow  = overflow_q;
   assign tile_done = out_valid_q && out_ready && out_last_q;
endmodule

// File: tb/tb_fused_tile_buffer.sv
// Randomised bench for fused_tile_buffer (DEPTH=4) against a queue-based tile model.
module tb_fused_tile_buffer;
   localparam int DEPTH = 4;
   localparam int DW    = 128;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;
   logic [1:0]    bank_full;
   logic          overflow;
   logic          tile_done;

   fused_tile_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .bank_full (bank_full),
      .overflow  (overflow),
      .tile_done (tile_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          last;
   } wrec_t;

   // Model: words of the tile being filled, words of completed tiles not yet
   // issued, and counters of completed / released tiles (tile t lives in bank t%2).
   logic [DW-1:0] fill_q[$];
   wrec_t         avail_q[$];
   int            m_done = 0;
   int            m_rel  = 0;
   logic          m_valid = 1'b0;
   logic          m_last  = 1'b0;
   logic          m_ovf   = 1'b0;
   logic [DW-1:0] m_data  = '0;

   logic [DW-1:0] sent_q[$];
   int vectors = 0;
   int miscompares = 0;
   int td_cnt = 0;
   int run_len = 0;
   int max_run = 0;
   bit chk_en = 1'b0;

   function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [1:0] m_bank_full();
      logic [1:0] r = 2'b00;
      for (int t = m_rel; t < m_done; t++) r[t % 2] = 1'b1;
      return r;
   endfunction

   task automatic model_step();
      logic  accept;
      logic  xfer;
      wrec_t w;
      if (reset) begin
         fill_q.delete();
         avail_q.delete();
         m_done = 0; m_rel = 0;
         m_valid = 1'b0; m_last = 1'b0; m_ovf = 1'b0; m_data = '0;
         return;
      end
      accept = (m_done - m_rel) < 2;
      xfer   = m_valid && out_ready;
      if (avail_q.size() != 0 && (!m_valid || out_ready)) begin
         w = avail_q.pop_front();
         m_data = w.d; m_last = w.last; m_valid = 1'b1;
         if (w.last) m_rel++;
      end else if (xfer) begin
         m_valid = 1'b0; m_last = 1'b0;
      end
      if (in_valid) begin
         if (accept) begin
            fill_q.push_back(in_data);
            if (fill_q.size() == DEPTH) begin
               for (int i = 0; i < DEPTH; i++) avail_q.push_back('{d: fill_q[i], last: (i == DEPTH - 1)});
               fill_q.delete();
               m_done++;
            end
         end else begin
            m_ovf = 1'b1;
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d, input bit keep);
      in_valid = 1'b1;
      in_data  = d;
      if (keep) sent_q.push_back(d);
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sent_q.delete();
      cyc();
      reset = 1'b0;
   endtask

   task automatic drain(input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         if (!out_valid && bank_full == 2'b00) break;
         cyc();
      end
      chk("drain_done", (!out_valid && bank_full == 2'b00), 1'b1);
   endtask

   function automatic logic [DW-1:0] rnd_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Per-cycle comparison against the model, plus an in-order delivery scoreboard.
   initial begin
      logic [DW-1:0] exp_w;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("out_valid", out_valid, m_valid);
            chk("out_last", out_last, m_last);
            chk("out_data", out_data, m_data);
            chk("bank_full", bank_full, m_bank_full());
            chk("overflow", overflow, m_ovf);
            chk("tile_done", tile_done, m_valid && out_ready && m_last);
            if (tile_done) td_cnt++;
            if (out_valid) run_len++; else run_len = 0;
            if (run_len > max_run) max_run = run_len;
            if (out_valid && out_ready) begin
               if (sent_q.size() == 0) begin
                  chk("unexpected_word", out_data, '0);
                  if (out_data == '0) begin
                     miscompares++;
                     $display("FAIL unexpected_word: got %h expected none", out_data);
                  end
               end else begin
                  exp_w = sent_q.pop_front();
                  chk("order", out_data, exp_w);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] w1;
      logic [DW-1:0] word;
      int td0;
      int nsent;

      // Test 1: single tile, ready held high.
      cyc(); cyc();
      reset = 1'b0;
      chk_en = 1'b1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, '0);
      chk("rst_bank_full", bank_full, 2'b00);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_tile_done", tile_done, 1'b0);
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         word = DW'(i);
         push(word, 1'b1);
      end
      chk("t1_bank_full", bank_full, 2'b01);
      chk("t1_valid_wait", out_valid, 1'b0);
      cyc();
      chk("t1_first_valid", out_valid, 1'b1);
      chk("t1_word1", out_data, DW'(1));
      chk("t1_last1", out_last, 1'b0);
      for (int i = 2; i <= 4; i++) begin
         cyc();
         chk("t1_word", out_data, DW'(i));
      end
      chk("t1_last4", out_last, 1'b1);
      chk("t1_tile_done", tile_done, 1'b1);
      chk("t1_bank_free", bank_full, 2'b00);
      cyc();
      chk("t1_idle", out_valid, 1'b0);

      // Test 2: both banks fill under stall, ninth word dropped.
      out_ready = 1'b0;
      w1 = rnd_word();
      push(w1, 1'b1);
      for (int i = 2; i <= 8; i++) push(rnd_word(), 1'b1);
      cyc(); cyc();
      chk("t2_both_full", bank_full, 2'b11);
      chk("t2_holding", out_valid, 1'b1);
      chk("t2_hold_word1", out_data, w1);
      push(rnd_word(), 1'b0);
      chk("t2_overflow", overflow, 1'b1);
      td0 = td_cnt;
      out_ready = 1'b1;
      drain(100);
      chk("t2_tiles", DW'(td_cnt - td0), DW'(2));
      chk("t2_all_seen", DW'(sent_q.size()), '0);

      // Test 3: continuous 12-word stream.
      do_reset();
      out_ready = 1'b1;
      max_run = 0;
      for (int i = 0; i < 12; i++) push(rnd_word(), 1'b1);
      drain(100);
      chk("t3_no_gap", DW'(max_run), DW'(12));
      chk("t3_no_overflow", overflow, 1'b0);

      // Test 4: random ready and random input spacing over 5 tiles.
      do_reset();
      td0 = td_cnt;
      nsent = 0;
      for (int k = 0; k < 3000; k++) begin
         if (nsent == 5 * DEPTH && !out_valid && bank_full == 2'b00) break;
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = (nsent < 5 * DEPTH) && ($urandom_range(0, 1) == 1) && ((m_done - m_rel) < 2);
         in_data   = rnd_word();
         if (in_valid) begin
            sent_q.push_back(in_data);
            nsent++;
         end
         cyc();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain(100);
      chk("t4_tiles", DW'(td_cnt - td0), DW'(5));
      chk("t4_all_seen", DW'(sent_q.size()), '0);
      chk("t4_no_overflow", overflow, 1'b0);

      // Test 5: reset mid-tile and while output valid.
      do_reset();
      push(rnd_word(), 1'b1);
      push(rnd_word(), 1'b1);
      do_reset();
      chk("t5_rst1_valid", out_valid, 1'b0);
      chk("t5_rst1_full", bank_full, 2'b00);
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(rnd_word(), 1'b1);
      cyc(); cyc();
      chk("t5_valid_before", out_valid, 1'b1);
      do_reset();
      chk("t5_rst2_valid", out_valid, 1'b0);
      chk("t5_rst2_last", out_last, 1'b0);
      chk("t5_rst2_data", out_data, '0);
      chk("t5_rst2_full", bank_full, 2'b00);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(rnd_word(), 1'b1);
      chk("t5_bank0", bank_full, 2'b01);
      drain(100);
      chk("t5_all_seen", DW'(sent_q.size()), '0);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
